// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
// CFG_SEQ_DELAY_EN adds the delay-entry table row and the StDelay state.
package i2c_cfg_pkg;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

`ifdef CFG_SEQ_DELAY_EN
    localparam int unsigned NUM_ENTRIES = 4;
`else
    localparam int unsigned NUM_ENTRIES = 3;
`endif

    localparam logic [7:0] DELAY_REG = 8'hFF;

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StIssue,
        StGap,
        StWait,
        StNext,
        StDone,
        StFail
`ifdef CFG_SEQ_DELAY_EN
        ,
        StDelay
`endif
    } state_e;

endpackage

// File: rtl/i2c_config_rom.sv
// Combinational configuration table; rows past the end read back as all zeros.
// CFG_SEQ_DELAY_EN inserts a delay row (DELAY_REG) after the first write.
module i2c_config_rom
    import i2c_cfg_pkg::*;
(
    input  logic [7:0] index_i,
    output cfg_entry_t entry_o
);

    always_comb begin
        entry_o = '{reg_addr: 8'h00, data: 8'h00};
        case (index_i)
`ifdef CFG_SEQ_DELAY_EN
            8'd0: entry_o = '{reg_addr: 8'h12, data: 8'h80};
            8'd1: entry_o = '{reg_addr: DELAY_REG, data: 8'h05};
            8'd2: entry_o = '{reg_addr: 8'h11, data: 8'h01};
            8'd3: entry_o = '{reg_addr: 8'h40, data: 8'hD0};
`else
            8'd0: entry_o = '{reg_addr: 8'h12, data: 8'h80};
            8'd1: entry_o = '{reg_addr: 8'h11, data: 8'h01};
            8'd2: entry_o = '{reg_addr: 8'h40, data: 8'hD0};
`endif
            default: entry_o = '{reg_addr: 8'h00, data: 8'h00};
        endcase
    end

endmodule

// File: rtl/i2c_config_seq.sv
// Walks the configuration table, issuing one I2C register write per row with retry/timeout.
// CFG_SEQ_DELAY_EN turns DELAY_REG rows into data*DELAY_UNIT-cycle pauses.
module i2c_config_seq
    import i2c_cfg_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR     = 7'h21,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 512,
    parameter int unsigned DELAY_UNIT     = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       fail_o,
    output logic [7:0] fail_index_o,
    output logic [6:0] slav_addr_o,
    output logic       read_not_write_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] write_data_o,
    output logic       write_valid_o,
    input  logic       write_ready_i,
    input  logic       error_i
);

    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned WaitW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);
    localparam logic [WaitW-1:0]  WaitLast  = WaitW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        LastIndex = 8'(NUM_ENTRIES - 1);

    state_e            state_q, state_d;
    logic [7:0]        index_q, index_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [7:0]        fail_index_q, fail_index_d;
    logic [7:0]        reg_addr_q, reg_addr_d;
    logic [7:0]        write_data_q, write_data_d;
    logic              err_now, timed_out;
    cfg_entry_t        rom_entry;

`ifdef CFG_SEQ_DELAY_EN
    localparam int unsigned DelayW = $clog2(255 * DELAY_UNIT + 1);
    logic [DelayW-1:0] delay_cnt_q, delay_cnt_d;
`endif

    i2c_config_rom u_rom (
        .index_i (index_q),
        .entry_o (rom_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            index_q      <= '0;
            retry_q      <= '0;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
            fail_index_q <= '0;
            reg_addr_q   <= '0;
            write_data_q <= '0;
`ifdef CFG_SEQ_DELAY_EN
            delay_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            retry_q      <= retry_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
            fail_index_q <= fail_index_d;
            reg_addr_q   <= reg_addr_d;
            write_data_q <= write_data_d;
`ifdef CFG_SEQ_DELAY_EN
            delay_cnt_q  <= delay_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        retry_d      = retry_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        fail_index_d = fail_index_q;
        reg_addr_d   = reg_addr_q;
        write_data_d = write_data_q;
`ifdef CFG_SEQ_DELAY_EN
        delay_cnt_d  = delay_cnt_q;
`endif
        // An error seen together with write_ready still fails the transaction.
        err_now   = err_q | error_i;
        timed_out = (wait_cnt_q == WaitLast) && !write_ready_i;

        case (state_q)
            StIdle, StDone, StFail: begin
                if (start_i) begin
                    index_d      = '0;
                    retry_d      = '0;
                    fail_index_d = '0;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                reg_addr_d   = rom_entry.reg_addr;
                write_data_d = rom_entry.data;
                err_d        = 1'b0;
                wait_cnt_d   = '0;
`ifdef CFG_SEQ_DELAY_EN
                if (rom_entry.reg_addr == DELAY_REG) begin
                    delay_cnt_d = DelayW'(rom_entry.data) * DelayW'(DELAY_UNIT);
                    state_d     = StDelay;
                end else begin
                    state_d = StIssue;
                end
`else
                state_d = StIssue;
`endif
            end
            StIssue: begin
                if (write_ready_i) begin
                    err_d      = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = StGap;
                end
            end
            StGap: begin
                // Master may still show ready from before it took the request.
                state_d = StWait;
            end
            StWait: begin
                if (write_ready_i || timed_out) begin
                    err_d      = 1'b0;
                    wait_cnt_d = '0;
                    if (!(err_now || timed_out)) begin
                        retry_d = '0;
                        state_d = StNext;
                    end else if (retry_q < RetryMax) begin
                        retry_d = retry_q + RetryW'(1);
                        state_d = StIssue;
                    end else begin
                        fail_index_d = index_q;
                        state_d      = StFail;
                    end
                end else begin
                    err_d      = err_now;
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StNext: begin
                index_d = index_q + 8'd1;
                state_d = (index_q == LastIndex) ? StDone : StLoad;
            end
`ifdef CFG_SEQ_DELAY_EN
            StDelay: begin
                if (delay_cnt_q <= DelayW'(1)) begin
                    delay_cnt_d = '0;
                    state_d     = StNext;
                end else begin
                    delay_cnt_d = delay_cnt_q - DelayW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign busy_o           = !(state_q inside {StIdle, StDone, StFail});
    assign done_o           = (state_q == StDone);
    assign fail_o           = (state_q == StFail);
    assign fail_index_o     = fail_index_q;
    assign slav_addr_o      = SLAVE_ADDR;
    assign read_not_write_o = 1'b0;
    assign reg_addr_o       = reg_addr_q;
    assign write_data_o     = write_data_q;
    assign write_valid_o    = (state_q == StIssue);

endmodule

// File: tb/tb_i2c_config_seq.sv
// Bench for i2c_config_seq: behavioural master plus a queue of expected handshakes.
module tb_i2c_config_seq;

    localparam int unsigned MaxRetry = 3;

`ifdef CFG_SEQ_DELAY_EN
    localparam int NumRows = 4;
    localparam int NackRow = 2;
    localparam int ExhRow  = 3;
    localparam int unsigned ExpGap1 = 136;
    logic [7:0] rom_reg [4] = '{8'h12, 8'hFF, 8'h11, 8'h40};
    logic [7:0] rom_dat [4] = '{8'h80, 8'h05, 8'h01, 8'hD0};
`else
    localparam int NumRows = 3;
    localparam int NackRow = 1;
    localparam int ExhRow  = 2;
    localparam int unsigned ExpGap1 = 34;
    logic [7:0] rom_reg [3] = '{8'h12, 8'h11, 8'h40};
    logic [7:0] rom_dat [3] = '{8'h80, 8'h01, 8'hD0};
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       write_ready = 1'b1;
    logic       error = 1'b0;
    logic       busy, done, fail, rnw, write_valid;
    logic [7:0] fail_index, reg_addr, write_data;
    logic [6:0] slav_addr;

    i2c_config_seq #(
        .SLAVE_ADDR     (7'h21),
        .MAX_RETRY      (MaxRetry),
        .TIMEOUT_CYCLES (64),
        .DELAY_UNIT     (20)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .busy_o           (busy),
        .done_o           (done),
        .fail_o           (fail),
        .fail_index_o     (fail_index),
        .slav_addr_o      (slav_addr),
        .read_not_write_o (rnw),
        .reg_addr_o       (reg_addr),
        .write_data_o     (write_data),
        .write_valid_o    (write_valid),
        .write_ready_i    (write_ready),
        .error_i          (error)
    );

    always #5 clk = ~clk;

    // emode: 0 clean, 1 error pulse mid-transaction, 2 error with ready, 3 ready held past timeout
    typedef struct {
        logic [7:0]  ra;
        logic [7:0]  wd;
        int unsigned emode;
    } txn_t;

    txn_t        exp_q[$];
    int unsigned rise_gap[$];
    txn_t        cur = '{8'h00, 8'h00, 0};
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned n_hs = 0;
    int unsigned cyc = 0;
    int unsigned hs_cyc = 0;
    int unsigned hold = 0;
    bit          drop_pend = 1'b0;
    bit          force_low = 1'b0;
    logic        wv_prev = 1'b0;

    // Master model: everything at negedge so DUT inputs are stable across the posedge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            drop_pend   = 1'b0;
            hold        = 0;
            write_ready = 1'b1;
            error       = 1'b0;
            wv_prev     = 1'b0;
        end else begin
            error = 1'b0;
            if (drop_pend) begin
                drop_pend   = 1'b0;
                write_ready = 1'b0;
                hold        = (cur.emode == 3) ? 100 : 30;
            end else if (hold > 0) begin
                hold--;
                if (cur.emode == 1 && hold == 15) error = 1'b1;
                if (hold == 0 && cur.emode == 2) error = 1'b1;
            end
            if (force_low) write_ready = 1'b0;
            else if (hold == 0 && !drop_pend) write_ready = 1'b1;

            if (write_valid && !wv_prev) rise_gap.push_back(cyc - hs_cyc);
            wv_prev = write_valid;

            if (write_valid && write_ready) begin
                n_hs++;
                hs_cyc = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_handshake: got %h:%h want none", reg_addr, write_data);
                    cur = '{8'h00, 8'h00, 0};
                end else begin
                    cur = exp_q.pop_front();
                    if ({reg_addr, write_data} !== {cur.ra, cur.wd}) begin
                        n_fail++;
                        $display("FAIL handshake_data: got %h:%h want %h:%h",
                                 reg_addr, write_data, cur.ra, cur.wd);
                    end
                end
                drop_pend = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_walk(input int err_row, input int unsigned emode, input int unsigned n_err);
        for (int r = 0; r < NumRows; r++) begin
`ifdef CFG_SEQ_DELAY_EN
            if (rom_reg[r] == 8'hFF) continue;
`endif
            if (r == err_row) begin
                for (int a = 0; a < int'(n_err); a++) exp_q.push_back('{rom_reg[r], rom_dat[r], emode});
                if (n_err > MaxRetry) return;
            end
            exp_q.push_back('{rom_reg[r], rom_dat[r], 0});
        end
    endtask

    task automatic wait_end(input string name);
        int k = 0;
        while (!(done || fail) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!(done || fail)) begin
            n_fail++;
            $display("FAIL %s_finish: got busy=%b want done or fail within 3000 cycles", name, busy);
        end
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", fail); end
        n_checks++; if (fail_index !== 8'h00) begin n_fail++; $display("FAIL reset_fail_index: got %h want 00", fail_index); end
        n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL reset_write_valid: got %b want 0", write_valid); end
        n_checks++; if ({reg_addr, write_data} !== 16'h0000) begin n_fail++; $display("FAIL reset_reg_data: got %h:%h want 00:00", reg_addr, write_data); end
        n_checks++; if (slav_addr !== 7'h21) begin n_fail++; $display("FAIL slave_addr: got %h want 21", slav_addr); end
        n_checks++; if (rnw !== 1'b0) begin n_fail++; $display("FAIL read_not_write: got %b want 0", rnw); end
        rst_n = 1'b1;
        tick(5);
        n_checks++; if (busy !== 1'b0 || write_valid !== 1'b0) begin n_fail++; $display("FAIL idle_without_start: got busy=%b wv=%b want 0/0", busy, write_valid); end
    endtask

    task automatic test_clean_walk();
        int unsigned hs0 = n_hs;
        rise_gap.delete();
        push_walk(-1, 0, 0);
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clean_busy_after_start: got %b want 1", busy); end
        wait_end("clean");
        n_checks++; if ({done, fail, busy} !== 3'b100) begin n_fail++; $display("FAIL clean_status: got done=%b fail=%b busy=%b want 1/0/0", done, fail, busy); end
        n_checks++; if (n_hs - hs0 != 3 || exp_q.size() != 0) begin n_fail++; $display("FAIL clean_count: got %0d handshakes want 3", n_hs - hs0); end
        n_checks++; if (rise_gap.size() < 2 || rise_gap[1] != ExpGap1) begin n_fail++; $display("FAIL gap_after_entry0: got %0d want %0d", (rise_gap.size() < 2) ? 0 : rise_gap[1], ExpGap1); end
    endtask

    task automatic test_single_nack();
        int unsigned hs0 = n_hs;
        push_walk(NackRow, 1, 1);
        pulse_start();
        wait_end("nack");
        n_checks++; if ({done, fail} !== 2'b10) begin n_fail++; $display("FAIL nack_status: got done=%b fail=%b want 1/0", done, fail); end
        n_checks++; if (n_hs - hs0 != 4 || exp_q.size() != 0) begin n_fail++; $display("FAIL nack_count: got %0d handshakes want 4", n_hs - hs0); end
    endtask

    task automatic test_retry_exhaust();
        int unsigned hs0 = n_hs;
        int unsigned hs1;
        push_walk(ExhRow, 2, MaxRetry + 1);
        pulse_start();
        wait_end("exhaust");
        n_checks++; if ({done, fail} !== 2'b01) begin n_fail++; $display("FAIL exhaust_status: got done=%b fail=%b want 0/1", done, fail); end
        n_checks++; if (fail_index !== 8'(ExhRow)) begin n_fail++; $display("FAIL exhaust_fail_index: got %0d want %0d", fail_index, ExhRow); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL exhaust_pending: got %0d left want 0", exp_q.size()); end
        hs1 = n_hs;
        tick(200);
        n_checks++; if (n_hs != hs1 || busy !== 1'b0 || fail !== 1'b1) begin n_fail++; $display("FAIL exhaust_quiet: got %0d extra busy=%b fail=%b want 0/0/1", n_hs - hs1, busy, fail); end
        n_checks++; if (hs1 - hs0 != int'(ExhRow) + MaxRetry + 1 - ((NumRows == 4) ? 1 : 0)) begin n_fail++; $display("FAIL exhaust_count: got %0d handshakes", hs1 - hs0); end
    endtask

    task automatic test_timeout();
        int unsigned g;
        rise_gap.delete();
        push_walk(0, 3, MaxRetry + 1);
        pulse_start();
        wait_end("timeout");
        g = (rise_gap.size() > 0) ? rise_gap[rise_gap.size() - 1] : 0;
        n_checks++; if ({done, fail} !== 2'b01 || fail_index !== 8'h00) begin n_fail++; $display("FAIL timeout_status: got fail=%b idx=%0d want 1/0", fail, fail_index); end
        n_checks++; if (g != 66) begin n_fail++; $display("FAIL timeout_retry_gap: got %0d want 66", g); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL timeout_pending: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int unsigned hs0 = n_hs;
        push_walk(-1, 0, 0);
        pulse_start();
        n_checks++; if (busy !== 1'b1 || fail !== 1'b0) begin n_fail++; $display("FAIL restart_from_fail: got busy=%b fail=%b want 1/0", busy, fail); end
        tick(10);
        pulse_start();
        wait_end("b2b_first");
        push_walk(-1, 0, 0);
        pulse_start();
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL restart_from_done: got busy=%b done=%b want 1/0", busy, done); end
        wait_end("b2b_second");
        n_checks++; if (done !== 1'b1 || n_hs - hs0 != 6 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_count: got %0d handshakes done=%b want 6/1", n_hs - hs0, done); end
    endtask

    task automatic test_reset_mid_issue();
        int unsigned hs0;
        int k = 0;
        exp_q.delete();
        force_low = 1'b1;
        pulse_start();
        while (!write_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (write_valid !== 1'b1) begin n_fail++; $display("FAIL issue_reached: got wv=%b want 1", write_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (write_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_wv: got %b want 0", write_valid); end
        n_checks++; if ({busy, done, fail, reg_addr, write_data} !== 19'h0) begin n_fail++; $display("FAIL async_reset_outputs: got busy=%b %h:%h want 0 00:00", busy, reg_addr, write_data); end
        tick(2);
        rst_n = 1'b1;
        force_low = 1'b0;
        hs0 = n_hs;
        tick(50);
        n_checks++; if (n_hs != hs0 || busy !== 1'b0 || write_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_quiet: got hs=%0d busy=%b want 0/0", n_hs - hs0, busy); end
        push_walk(-1, 0, 0);
        pulse_start();
        wait_end("post_reset");
        n_checks++; if (done !== 1'b1 || n_hs - hs0 != 3 || exp_q.size() != 0) begin n_fail++; $display("FAIL post_reset_walk: got %0d handshakes done=%b want 3/1", n_hs - hs0, done); end
    endtask

    initial begin
        test_reset();
        test_clean_walk();
        test_single_nack();
        test_retry_exhaust();
        test_timeout();
        test_back_to_back();
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
